alu: RTL and testbench

Single-issue integer execution stage directly downstream of the reservation station (`RS`). It accepts one ready instruction per cycle, computes the integer result and any branch/jump decision, and buffers results in a 2-entry FIFO until the common data bus grants a broadcast slot. It is flushed by `rollback`. It applies back-pressure to `RS` through `alu_full`.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_calc.sv | 87 ++++++++
 rtl/alu.sv | 83 ++++++++
 tb/tb_alu.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and the result-buffer entry for the integer ALU.
package alu_pkg;

    localparam int ROB_WID  = 4;
    localparam int DATA_WID = 32;
    localparam int ADDR_WID = 32;
    localparam int ALU_FIFO_DEPTH = 2;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    typedef struct packed {
        logic [DATA_WID-1:0] res;
        logic [ROB_WID-1:0]  rob_pos;
        logic                jump;
        logic [ADDR_WID-1:0] pc;
    } alu_ent_t;

endpackage

// File: rtl/alu_calc.sv
// Combinational RV32I integer datapath: result, branch decision, next PC.
module alu_calc
    import alu_pkg::*;
(
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7,
    input  logic [DATA_WID-1:0] val1,
    input  logic [DATA_WID-1:0] val2,
    input  logic [DATA_WID-1:0] imm,
    input  logic [ADDR_WID-1:0] pc,
    output logic [DATA_WID-1:0] res,
    output logic                jump,
    output logic [ADDR_WID-1:0] npc
);

    logic [DATA_WID-1:0]        op2;
    logic [4:0]                 sh;
    logic signed [DATA_WID-1:0] sra_v;
    logic [DATA_WID-1:0]        arith;
    logic [DATA_WID-1:0]        jalr_t;
    logic [ADDR_WID-1:0]        pc4;
    logic                       take;

    assign op2    = (opcode == OPC_OPI) ? imm : val2;
    assign sh     = op2[4:0];
    // Kept in its own signed net so the shift stays arithmetic.
    assign sra_v  = $signed(val1) >>> sh;
    assign jalr_t = val1 + imm;
    assign pc4    = pc + ADDR_WID'(4);

    always_comb begin
        arith = '0;
        unique case (funct3)
            3'b000: arith = (opcode == OPC_OP && funct7) ? val1 - op2
                                                         : val1 + op2;
            3'b001: arith = val1 << sh;
            3'b010: arith = {{(DATA_WID-1){1'b0}},
                             $signed(val1) < $signed(op2)};
            3'b011: arith = {{(DATA_WID-1){1'b0}}, val1 < op2};
            3'b100: arith = val1 ^ op2;
            3'b101: arith = funct7 ? sra_v : val1 >> sh;
            3'b110: arith = val1 | op2;
            3'b111: arith = val1 & op2;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = val1 == val2;
            3'b001:  take = val1 != val2;
            3'b100:  take = $signed(val1) < $signed(val2);
            3'b101:  take = $signed(val1) >= $signed(val2);
            3'b110:  take = val1 < val2;
            3'b111:  take = val1 >= val2;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        res  = '0;
        jump = 1'b0;
        npc  = pc4;
        case (opcode)
            OPC_OP, OPC_OPI: res = arith;
            OPC_LUI:         res = imm;
            OPC_AUIPC:       res = pc + imm;
            OPC_JAL: begin
                res  = pc4;
                jump = 1'b1;
                npc  = pc + imm;
            end
            OPC_JALR: begin
                res  = pc4;
                jump = 1'b1;
                npc  = {jalr_t[ADDR_WID-1:1], 1'b0};
            end
            OPC_BR: begin
                jump = take;
                if (take) npc = pc + imm;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Integer execution stage: computes one op per cycle and buffers results
// in a 2-entry FIFO until the CDB grants a broadcast.
module alu
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                alu_en,
    input  logic [ROB_WID-1:0]  alu_rob_pos,
    input  logic [6:0]          alu_opcode,
    input  logic [2:0]          alu_funct3,
    input  logic                alu_funct7,
    input  logic [DATA_WID-1:0] alu_val1,
    input  logic [DATA_WID-1:0] alu_val2,
    input  logic [DATA_WID-1:0] alu_imm,
    input  logic [ADDR_WID-1:0] alu_pc,
    output logic                alu_full,
    input  logic                cdb_grant,
    output logic                alu_done,
    output logic [DATA_WID-1:0] alu_res,
    output logic [ROB_WID-1:0]  alu_res_rob_pos,
    output logic                alu_res_jump,
    output logic [ADDR_WID-1:0] alu_res_pc
);

    alu_ent_t   mem [ALU_FIFO_DEPTH];
    alu_ent_t   ent;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       push;
    logic       pop;

    alu_calc u_calc (
        .opcode (alu_opcode),
        .funct3 (alu_funct3),
        .funct7 (alu_funct7),
        .val1   (alu_val1),
        .val2   (alu_val2),
        .imm    (alu_imm),
        .pc     (alu_pc),
        .res    (ent.res),
        .jump   (ent.jump),
        .npc    (ent.pc)
    );

    assign ent.rob_pos = alu_rob_pos;

    assign alu_done = (cnt != 2'd0);
    assign alu_full = (cnt == 2'd2);

    assign pop  = alu_done && cdb_grant && rdy;
    // A full buffer only takes a new entry when the head leaves this cycle.
    assign push = alu_en && rdy && !rollback && (!alu_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALU_FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (rollback) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (rdy) begin
            if (push) begin
                mem[wr_ptr] <= ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign alu_res         = mem[rd_ptr].res;
    assign alu_res_rob_pos = mem[rd_ptr].rob_pos;
    assign alu_res_jump    = mem[rd_ptr].jump;
    assign alu_res_pc      = mem[rd_ptr].pc;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu execution stage.
module tb_alu;
    import alu_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                rdy;
    logic                rollback;
    logic                alu_en;
    logic [ROB_WID-1:0]  alu_rob_pos;
    logic [6:0]          alu_opcode;
    logic [2:0]          alu_funct3;
    logic                alu_funct7;
    logic [DATA_WID-1:0] alu_val1;
    logic [DATA_WID-1:0] alu_val2;
    logic [DATA_WID-1:0] alu_imm;
    logic [ADDR_WID-1:0] alu_pc;
    logic                alu_full;
    logic                cdb_grant;
    logic                alu_done;
    logic [DATA_WID-1:0] alu_res;
    logic [ROB_WID-1:0]  alu_res_rob_pos;
    logic                alu_res_jump;
    logic [ADDR_WID-1:0] alu_res_pc;

    logic [69:0] obs;
    logic [69:0] exp;
    int checks = 0;
    int errors = 0;

    assign obs = {alu_done, alu_res, alu_res_rob_pos, alu_res_jump, alu_res_pc};

    always #5 clk = ~clk;

    alu dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback        (rollback),
        .alu_en          (alu_en),
        .alu_rob_pos     (alu_rob_pos),
        .alu_opcode      (alu_opcode),
        .alu_funct3      (alu_funct3),
        .alu_funct7      (alu_funct7),
        .alu_val1        (alu_val1),
        .alu_val2        (alu_val2),
        .alu_imm         (alu_imm),
        .alu_pc          (alu_pc),
        .alu_full        (alu_full),
        .cdb_grant       (cdb_grant),
        .alu_done        (alu_done),
        .alu_res         (alu_res),
        .alu_res_rob_pos (alu_res_rob_pos),
        .alu_res_jump    (alu_res_jump),
        .alu_res_pc      (alu_res_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob);
        alu_en      = 1'b1;
        alu_opcode  = opc;
        alu_funct3  = f3;
        alu_funct7  = f7;
        alu_val1    = v1;
        alu_val2    = v2;
        alu_imm     = imm;
        alu_pc      = pc;
        alu_rob_pos = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
        cdb_grant = 1'b0; alu_rob_pos = '0; alu_opcode = '0;
        alu_funct3 = '0; alu_funct7 = 1'b0; alu_val1 = '0;
        alu_val2 = '0; alu_imm = '0; alu_pc = '0;
        repeat (2) step();
        checks++;
        if (obs !== 70'd0) begin
            errors++; $display("FAIL reset_head got %h want 0", obs);
        end
        checks++;
        if (alu_full !== 1'b0) begin
            errors++; $display("FAIL reset_full got %b want 0", alu_full);
        end
        rst = 1'b0;
        issue(OPC_OPI, 3'b000, 1'b0, 32'd1, 32'd0, 32'd2, 32'h0, 4'd1);
        step();
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h4, 4'd2);
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'd3, 4'd1, 1'b0, 32'h4};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL pre_reset got %h want %h", obs, exp);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 70'd0) begin
            errors++; $display("FAIL async_reset got %h want 0", obs);
        end
        checks++;
        if (alu_full !== 1'b0) begin
            errors++; $display("FAIL async_full got %b want 0", alu_full);
        end
        step();
        rst = 1'b0;
        cdb_grant = 1'b1;
        issue(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'h8, 4'd2);
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'd7, 4'd2, 1'b0, 32'hC};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL post_reset got %h want %h", obs, exp);
        end
        step();
        checks++;
        if (alu_done !== 1'b0) begin
            errors++; $display("FAIL post_drain got %b want 0", alu_done);
        end
    endtask

    task automatic test_arith();
        cdb_grant = 1'b1;
        issue(OPC_OP, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h10, 4'd3);
        step();
        exp = {1'b1, 32'hFFFFFFFE, 4'd3, 1'b0, 32'h14};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL sub got %h want %h", obs, exp);
        end
        issue(OPC_OPI, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h404,
              32'h20, 4'd4);
        step();
        exp = {1'b1, 32'hF8000000, 4'd4, 1'b0, 32'h24};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL srai got %h want %h", obs, exp);
        end
        issue(OPC_OPI, 3'b000, 1'b1, 32'd10, 32'd100, 32'd5, 32'h30, 4'd5);
        step();
        exp = {1'b1, 32'd15, 4'd5, 1'b0, 32'h34};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL addi_f7 got %h want %h", obs, exp);
        end
        issue(OPC_OP, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h40, 4'd6);
        step();
        exp = {1'b1, 32'd1, 4'd6, 1'b0, 32'h44};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL slt got %h want %h", obs, exp);
        end
        issue(OPC_OP, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h48, 4'd7);
        step();
        exp = {1'b1, 32'd0, 4'd7, 1'b0, 32'h4C};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL sltu got %h want %h", obs, exp);
        end
        issue(OPC_OP, 3'b101, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'h50, 4'd8);
        step();
        exp = {1'b1, 32'h08000000, 4'd8, 1'b0, 32'h54};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL srl got %h want %h", obs, exp);
        end
        issue(OPC_OP, 3'b001, 1'b0, 32'h3, 32'h21, 32'd0, 32'h58, 4'd9);
        step();
        exp = {1'b1, 32'h6, 4'd9, 1'b0, 32'h5C};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL sll got %h want %h", obs, exp);
        end
        issue(OPC_LUI, 3'b000, 1'b0, 32'd9, 32'd9, 32'h12345000,
              32'h60, 4'd10);
        step();
        exp = {1'b1, 32'h12345000, 4'd10, 1'b0, 32'h64};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL lui got %h want %h", obs, exp);
        end
        issue(OPC_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h2000,
              32'h1000, 4'd11);
        step();
        exp = {1'b1, 32'h3000, 4'd11, 1'b0, 32'h1004};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL auipc got %h want %h", obs, exp);
        end
        issue(7'h7F, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'h70, 4'd12);
        step();
        exp = {1'b1, 32'd0, 4'd12, 1'b0, 32'h74};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL bad_opc got %h want %h", obs, exp);
        end
        alu_en = 1'b0;
        step();
    endtask

    task automatic test_branch();
        cdb_grant = 1'b1;
        issue(OPC_BR, 3'b001, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd1);
        step();
        exp = {1'b1, 32'd0, 4'd1, 1'b1, 32'h120};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL bne got %h want %h", obs, exp);
        end
        issue(OPC_BR, 3'b000, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd2);
        step();
        exp = {1'b1, 32'd0, 4'd2, 1'b0, 32'h104};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL beq got %h want %h", obs, exp);
        end
        issue(OPC_BR, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h8, 32'h200, 4'd3);
        step();
        exp = {1'b1, 32'd0, 4'd3, 1'b1, 32'h208};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL blt got %h want %h", obs, exp);
        end
        issue(OPC_BR, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h8, 32'h200, 4'd4);
        step();
        exp = {1'b1, 32'd0, 4'd4, 1'b0, 32'h204};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL bltu got %h want %h", obs, exp);
        end
        issue(OPC_BR, 3'b101, 1'b0, 32'd5, 32'd5, 32'h10, 32'h300, 4'd5);
        step();
        exp = {1'b1, 32'd0, 4'd5, 1'b1, 32'h310};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL bge got %h want %h", obs, exp);
        end
        issue(OPC_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFFFFF0,
              32'h200, 4'd6);
        step();
        exp = {1'b1, 32'h204, 4'd6, 1'b1, 32'h1F0};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL jal got %h want %h", obs, exp);
        end
        issue(OPC_JALR, 3'b000, 1'b0, 32'h203, 32'd0, 32'd0, 32'h40, 4'd7);
        step();
        exp = {1'b1, 32'h44, 4'd7, 1'b1, 32'h202};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL jalr got %h want %h", obs, exp);
        end
        alu_en = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        cdb_grant = 1'b0;
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        step();
        issue(OPC_OP, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 32'h4, 4'd2);
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'd2, 4'd1, 1'b0, 32'h4};
        checks++;
        if (alu_full !== 1'b1) begin
            errors++; $display("FAIL bp_full got %b want 1", alu_full);
        end
        repeat (2) step();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL bp_stable got %h want %h", obs, exp);
        end
        issue(OPC_OP, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 32'h30, 4'd7);
        step();
        alu_en = 1'b0;
        checks++;
        if ({alu_full, obs} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL bp_drop got %b/%h want 1/%h", alu_full, obs, exp);
        end
        cdb_grant = 1'b1;
        issue(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 32'h8, 4'd3);
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'd4, 4'd2, 1'b0, 32'h8};
        checks++;
        if ({alu_full, obs} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL bp_swap got %b/%h want 1/%h", alu_full, obs, exp);
        end
        step();
        exp = {1'b1, 32'd6, 4'd3, 1'b0, 32'hC};
        checks++;
        if ({alu_full, obs} !== {1'b0, exp}) begin
            errors++;
            $display("FAIL bp_third got %b/%h want 0/%h", alu_full, obs, exp);
        end
        step();
        checks++;
        if (alu_done !== 1'b0) begin
            errors++; $display("FAIL bp_empty got %b want 0", alu_done);
        end
    endtask

    task automatic test_rollback();
        cdb_grant = 1'b0;
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        step();
        issue(OPC_OP, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 32'h4, 4'd2);
        step();
        checks++;
        if (alu_full !== 1'b1) begin
            errors++; $display("FAIL rb_full got %b want 1", alu_full);
        end
        issue(OPC_OP, 3'b000, 1'b1, 32'd8, 32'd1, 32'd0, 32'h8, 4'd9);
        rollback = 1'b1;
        step();
        alu_en = 1'b0;
        rollback = 1'b0;
        checks++;
        if ({alu_done, alu_full} !== 2'b00) begin
            errors++;
            $display("FAIL rb_flush got %b%b want 00", alu_done, alu_full);
        end
        step();
        checks++;
        if (alu_done !== 1'b0) begin
            errors++; $display("FAIL rb_dropped got %b want 0", alu_done);
        end
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        step();
        alu_en = 1'b0;
        rdy = 1'b0;
        rollback = 1'b1;
        step();
        rdy = 1'b1;
        rollback = 1'b0;
        checks++;
        if (alu_done !== 1'b0) begin
            errors++; $display("FAIL rb_stalled got %b want 0", alu_done);
        end
        cdb_grant = 1'b1;
        issue(OPC_OP, 3'b100, 1'b0, 32'hF0, 32'hFF, 32'd0, 32'h60, 4'd5);
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'h0F, 4'd5, 1'b0, 32'h64};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL rb_resume got %h want %h", obs, exp);
        end
        step();
    endtask

    task automatic test_stall();
        cdb_grant = 1'b0;
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        step();
        exp = {1'b1, 32'd2, 4'd1, 1'b0, 32'h4};
        issue(OPC_OP, 3'b110, 1'b0, 32'h0F, 32'hF0, 32'd0, 32'h4, 4'd2);
        cdb_grant = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({alu_full, obs} !== {1'b0, exp}) begin
                errors++;
                $display("FAIL stall_%0d got %b/%h want 0/%h",
                         i, alu_full, obs, exp);
            end
        end
        rdy = 1'b1;
        step();
        alu_en = 1'b0;
        exp = {1'b1, 32'hFF, 4'd2, 1'b0, 32'h8};
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL stall_resume got %h want %h", obs, exp);
        end
        step();
        checks++;
        if (alu_done !== 1'b0) begin
            errors++; $display("FAIL stall_drain got %b want 0", alu_done);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_back_to_back();
        test_rollback();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
